// File: rtl/fault_led_driver_pkg.sv
// Shared definitions for the fault/pick/drop RGB indicator: FSM encoding,
// default timing constants and counter-width helpers.
package fault_led_driver_pkg;

    localparam int unsigned DEFAULT_CLK_PER_MS = 50000;
    localparam int unsigned DEFAULT_FAULT_MS   = 1000;
    localparam int unsigned DEFAULT_PICK_MS    = 500;
    localparam int unsigned DEFAULT_BLINK_MS   = 250;
    localparam int unsigned DEFAULT_BLINKS     = 3;

    localparam int unsigned COUNT_W = 4;
    typedef logic [COUNT_W-1:0] count_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FAULT_SHOW,
        ST_PICK_SHOW,
        ST_DROP_ON,
        ST_DROP_OFF
    } state_e;

    // Bits needed to hold every value in 0..max_value (at least one).
    function automatic int unsigned width_for(input int unsigned max_value);
        return (max_value < 2) ? 1 : $clog2(max_value + 1);
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/fault_led_driver_if.sv
// Event inputs and indicator/status outputs of the LED driver, bundled
// with a stimulus-side (master) and driver-side (slave) view.
interface fault_led_driver_if;
    import fault_led_driver_pkg::*;

    logic   fault_detect;
    logic   block_picked;
    logic   object_drop;
    logic   led_r;
    logic   led_g;
    logic   led_b;
    count_t fault_count;
    count_t drop_count;
    logic   busy;

    modport master (
        output fault_detect, block_picked, object_drop,
        input  led_r, led_g, led_b, fault_count, drop_count, busy
    );

    modport slave (
        input  fault_detect, block_picked, object_drop,
        output led_r, led_g, led_b, fault_count, drop_count, busy
    );

endinterface

// File: rtl/fault_led_driver_ms_timer.sv
// Millisecond timer: a clock prescaler feeding a ms counter; done pulses in
// the cycle the ms counter would reach the target.
module ms_timer
    import fault_led_driver_pkg::*;
#(
    parameter int unsigned CLK_PER_MS = DEFAULT_CLK_PER_MS,
    parameter int unsigned MS_W       = 10
) (
    input  logic            clk_50M,
    input  logic            reset,
    input  logic            clear_i,
    input  logic [MS_W-1:0] target_i,
    output logic            done_o
);

    localparam int unsigned PRE_W = width_for(CLK_PER_MS - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [MS_W-1:0]  ms_q, ms_d;
    logic             tick;

    assign tick   = (pre_q == PRE_W'(CLK_PER_MS - 1));
    assign done_o = tick && (ms_q == target_i - MS_W'(1));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pre_d = pre_q + PRE_W'(1);
        ms_d  = ms_q;
        if (clear_i) begin
            pre_d = '0;
            ms_d  = '0;
        end else if (tick) begin
            pre_d = '0;
            ms_d  = ms_q + MS_W'(1);
        end
    end

    // NOTE: registers use non-blocking assignments; reset is synchronous here.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            pre_q <= '0;
            ms_q  <= '0;
        end else begin
            pre_q <= pre_d;
            ms_q  <= ms_d;
        end
    end

endmodule

// File: rtl/fault_led_driver.sv
// RGB status indicator: queues fault, pick and drop events as pending flags
// and plays one timed colour pattern at a time (drop > fault > pick).
module fault_led_driver
    import fault_led_driver_pkg::*;
#(
    parameter int unsigned CLK_PER_MS = DEFAULT_CLK_PER_MS,
    parameter int unsigned FAULT_MS   = DEFAULT_FAULT_MS,
    parameter int unsigned PICK_MS    = DEFAULT_PICK_MS,
    parameter int unsigned BLINK_MS   = DEFAULT_BLINK_MS,
    parameter int unsigned BLINKS     = DEFAULT_BLINKS
) (
    input  logic               clk_50M,
    input  logic               reset,
    fault_led_driver_if.slave  bus
);

    localparam int unsigned MS_W    = width_for(max3(FAULT_MS, PICK_MS, BLINK_MS));
    localparam int unsigned BLINK_W = width_for(BLINKS);

    state_e             state_q, state_d;
    logic               fault_prev_q, pick_prev_q;
    logic               pend_fault_q, pend_fault_d;
    logic               pend_pick_q, pend_pick_d;
    logic               pend_drop_q, pend_drop_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    count_t             fault_cnt_q, fault_cnt_d;
    count_t             drop_cnt_q, drop_cnt_d;
    logic               led_r_q, led_g_q, led_b_q;

    logic               fault_evt, pick_evt, drop_evt;
    logic               timer_clear, timer_done;
    logic [MS_W-1:0]    timer_target;

    assign fault_evt = bus.fault_detect && !fault_prev_q;
    assign pick_evt  = bus.block_picked && !pick_prev_q;
    assign drop_evt  = bus.object_drop;

    always_comb begin
        timer_target = '0;
        case (state_q)
            ST_FAULT_SHOW:           timer_target = MS_W'(FAULT_MS);
            ST_PICK_SHOW:            timer_target = MS_W'(PICK_MS);
            ST_DROP_ON, ST_DROP_OFF: timer_target = MS_W'(BLINK_MS);
            default:                 timer_target = '0;
        endcase
    end

    // Held cleared in IDLE and on every state entry so each phase starts from zero.
    assign timer_clear = (state_q == ST_IDLE) || (state_d != state_q);

    ms_timer #(
        .CLK_PER_MS (CLK_PER_MS),
        .MS_W       (MS_W)
    ) u_ms_timer (
        .clk_50M  (clk_50M),
        .reset    (reset),
        .clear_i  (timer_clear),
        .target_i (timer_target),
        .done_o   (timer_done)
    );

    always_comb begin
        state_d      = state_q;
        pend_fault_d = pend_fault_q || fault_evt;
        pend_pick_d  = pend_pick_q || pick_evt;
        pend_drop_d  = pend_drop_q || drop_evt;
        blink_d      = blink_q;
        fault_cnt_d  = (fault_evt && fault_cnt_q != '1) ? fault_cnt_q + count_t'(1) : fault_cnt_q;
        drop_cnt_d   = (drop_evt && drop_cnt_q != '1) ? drop_cnt_q + count_t'(1) : drop_cnt_q;

        // Consuming a flag overrides an event of the same class arriving this cycle.
        case (state_q)
            ST_IDLE: begin
                if (pend_drop_q) begin
                    state_d     = ST_DROP_ON;
                    pend_drop_d = 1'b0;
                end else if (pend_fault_q) begin
                    state_d      = ST_FAULT_SHOW;
                    pend_fault_d = 1'b0;
                end else if (pend_pick_q) begin
                    state_d     = ST_PICK_SHOW;
                    pend_pick_d = 1'b0;
                end
            end
            ST_FAULT_SHOW, ST_PICK_SHOW: begin
                if (timer_done) state_d = ST_IDLE;
            end
            ST_DROP_ON: begin
                if (timer_done) state_d = ST_DROP_OFF;
            end
            ST_DROP_OFF: begin
                if (timer_done) begin
                    if (blink_q == BLINK_W'(BLINKS - 1)) begin
                        state_d = ST_IDLE;
                        blink_d = '0;
                    end else begin
                        state_d = ST_DROP_ON;
                        blink_d = blink_q + BLINK_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            fault_prev_q <= 1'b0;
            pick_prev_q  <= 1'b0;
            pend_fault_q <= 1'b0;
            pend_pick_q  <= 1'b0;
            pend_drop_q  <= 1'b0;
            blink_q      <= '0;
            fault_cnt_q  <= '0;
            drop_cnt_q   <= '0;
            led_r_q      <= 1'b0;
            led_g_q      <= 1'b0;
            led_b_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fault_prev_q <= bus.fault_detect;
            pick_prev_q  <= bus.block_picked;
            pend_fault_q <= pend_fault_d;
            pend_pick_q  <= pend_pick_d;
            pend_drop_q  <= pend_drop_d;
            blink_q      <= blink_d;
            fault_cnt_q  <= fault_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            led_r_q      <= (state_q == ST_FAULT_SHOW);
            led_g_q      <= (state_q == ST_DROP_ON);
            led_b_q      <= (state_q == ST_PICK_SHOW);
        end
    end

    assign bus.led_r       = led_r_q;
    assign bus.led_g       = led_g_q;
    assign bus.led_b       = led_b_q;
    assign bus.fault_count = fault_cnt_q;
    assign bus.drop_count  = drop_cnt_q;
    assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fault_led_driver.sv
// Self-checking bench for fault_led_driver with short timing parameters
// (10 clk/ms, fault 4 ms, pick 3 ms, blink 2 ms, 3 blinks).
module tb_fault_led_driver;

    logic clk_50M = 1'b0;
    logic reset   = 1'b1;

    fault_led_driver_if bus ();

    fault_led_driver #(
        .CLK_PER_MS (10),
        .FAULT_MS   (4),
        .PICK_MS    (3),
        .BLINK_MS   (2),
        .BLINKS     (3)
    ) dut (
        .clk_50M (clk_50M),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_50M = ~clk_50M;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    // Display monitor: samples on the falling edge while enabled.
    logic  mon_en = 1'b0;
    int    mon_busy, mon_r, mon_g, mon_b;
    int    g_run, g_gap, g_run_min, g_run_max, g_gap_min, g_gap_max;
    bit    g_seen;
    string seq;
    byte   last_col;

    task automatic clear_mon();
        mon_busy = 0; mon_r = 0; mon_g = 0; mon_b = 0;
        g_run = 0; g_gap = 0; g_seen = 0;
        g_run_min = 9999; g_run_max = 0; g_gap_min = 9999; g_gap_max = 0;
        seq = ""; last_col = 8'h00;
    endtask

    always @(negedge clk_50M) begin
        if (mon_en) begin
            byte col;
            col = 8'h00;
            if (bus.busy)  mon_busy++;
            if (bus.led_r) begin mon_r++; col = "R"; end
            if (bus.led_b) begin mon_b++; col = "B"; end
            if (bus.led_g) begin
                mon_g++;
                col = "G";
                if (g_gap > 0) begin
                    if (g_gap < g_gap_min) g_gap_min = g_gap;
                    if (g_gap > g_gap_max) g_gap_max = g_gap;
                end
                g_gap = 0;
                g_run++;
                g_seen = 1;
            end else begin
                if (g_run > 0) begin
                    if (g_run < g_run_min) g_run_min = g_run;
                    if (g_run > g_run_max) g_run_max = g_run;
                end
                g_run = 0;
                if (g_seen) g_gap++;
            end
            if (col != 8'h00 && col != last_col) begin
                seq = {seq, string'(col)};
                last_col = col;
            end
        end
    end

    task automatic do_reset();
        reset            = 1'b1;
        bus.fault_detect = 1'b0;
        bus.block_picked = 1'b0;
        bus.object_drop  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Waits until the driver has been idle with all LEDs dark for 4 samples.
    task automatic wait_quiet();
        int quiet;
        quiet = 0;
        for (int c = 0; c < 2000 && quiet < 4; c++) begin
            tick();
            if (!bus.busy && !bus.led_r && !bus.led_g && !bus.led_b) quiet++;
            else quiet = 0;
        end
        if (quiet < 4) check("wait_quiet timeout", 0, 1);
    endtask

    function automatic logic [11:0] outs();
        return {bus.busy, bus.led_r, bus.led_g, bus.led_b, bus.fault_count, bus.drop_count};
    endfunction

    typedef struct {
        logic        f;
        logic        p;
        logic        d;
        int          n;
        logic [11:0] exp;  // {busy, r, g, b, fault_count, drop_count}
    } vec_t;

    vec_t vecs[10];

    initial begin
        clear_mon();

        // Reset state
        do_reset();
        check("reset_outputs", int'(outs()), 0);

        // Pick display: edges, 30-cycle blue window, one-cycle LED lag, re-trigger
        vecs[0] = '{f:1'b0, p:1'b1, d:1'b0, n:1,  exp:12'b0_0_0_0_0000_0000};
        vecs[1] = '{f:1'b0, p:1'b1, d:1'b0, n:1,  exp:12'b1_0_0_0_0000_0000};
        vecs[2] = '{f:1'b0, p:1'b1, d:1'b0, n:1,  exp:12'b1_0_0_1_0000_0000};
        vecs[3] = '{f:1'b0, p:1'b1, d:1'b0, n:28, exp:12'b1_0_0_1_0000_0000};
        vecs[4] = '{f:1'b0, p:1'b1, d:1'b0, n:1,  exp:12'b0_0_0_1_0000_0000};
        vecs[5] = '{f:1'b0, p:1'b0, d:1'b0, n:1,  exp:12'b0_0_0_0_0000_0000};
        vecs[6] = '{f:1'b0, p:1'b1, d:1'b0, n:1,  exp:12'b0_0_0_0_0000_0000};
        vecs[7] = '{f:1'b0, p:1'b1, d:1'b0, n:1,  exp:12'b1_0_0_0_0000_0000};
        vecs[8] = '{f:1'b0, p:1'b0, d:1'b0, n:30, exp:12'b0_0_0_1_0000_0000};
        vecs[9] = '{f:1'b0, p:1'b0, d:1'b0, n:1,  exp:12'b0_0_0_0_0000_0000};
        for (int i = 0; i < 10; i++) begin
            bus.fault_detect = vecs[i].f;
            bus.block_picked = vecs[i].p;
            bus.object_drop  = vecs[i].d;
            for (int k = 0; k < vecs[i].n; k++) tick();
            check($sformatf("vec%0d", i), int'(outs()), int'(vecs[i].exp));
        end

        // Single fault, level held: one 40-cycle red display, no retrigger
        do_reset();
        clear_mon();
        mon_en = 1'b1;
        bus.fault_detect = 1'b1;
        wait_quiet();
        for (int k = 0; k < 20; k++) tick();
        mon_en = 1'b0;
        check("fault_red_cycles", mon_r, 40);
        check("fault_busy_cycles", mon_busy, 40);
        check("fault_seq_len", seq.len(), 1);
        check("fault_count", int'(bus.fault_count), 1);
        check("fault_no_retrigger_busy", int'(bus.busy), 0);
        bus.fault_detect = 1'b0;

        // Single drop: three 20-on / 20-off green blinks
        do_reset();
        clear_mon();
        mon_en = 1'b1;
        bus.object_drop = 1'b1;
        tick();
        bus.object_drop = 1'b0;
        wait_quiet();
        mon_en = 1'b0;
        check("drop_green_cycles", mon_g, 60);
        check("drop_on_min", g_run_min, 20);
        check("drop_on_max", g_run_max, 20);
        check("drop_off_min", g_gap_min, 20);
        check("drop_off_max", g_gap_max, 20);
        check("drop_busy_cycles", mon_busy, 120);
        check("drop_count", int'(bus.drop_count), 1);

        // Simultaneous events: drop, then fault, then pick
        do_reset();
        clear_mon();
        mon_en = 1'b1;
        bus.fault_detect = 1'b1;
        bus.block_picked = 1'b1;
        bus.object_drop  = 1'b1;
        tick();
        bus.fault_detect = 1'b0;
        bus.block_picked = 1'b0;
        bus.object_drop  = 1'b0;
        wait_quiet();
        mon_en = 1'b0;
        check("simul_order_GRB", int'(seq == "GRB"), 1);
        check("simul_busy_cycles", mon_busy, 190);
        check("simul_red_cycles", mon_r, 40);
        check("simul_green_cycles", mon_g, 60);
        check("simul_blue_cycles", mon_b, 30);
        check("simul_fault_count", int'(bus.fault_count), 1);
        check("simul_drop_count", int'(bus.drop_count), 1);

        // Merging: three fault edges during a drop display -> one red display
        do_reset();
        clear_mon();
        mon_en = 1'b1;
        bus.object_drop = 1'b1;
        tick();
        bus.object_drop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.fault_detect = 1'b1;
            tick();
            bus.fault_detect = 1'b0;
            tick();
        end
        check("merge_fault_count", int'(bus.fault_count), 3);
        wait_quiet();
        mon_en = 1'b0;
        check("merge_order_GR", int'(seq == "GR"), 1);
        check("merge_red_cycles", mon_r, 40);
        check("merge_busy_cycles", mon_busy, 160);

        // Saturation: 20 fault edges
        do_reset();
        for (int k = 0; k < 20; k++) begin
            bus.fault_detect = 1'b1;
            tick();
            bus.fault_detect = 1'b0;
            tick();
            if (k == 14) check("sat_at_15_events", int'(bus.fault_count), 15);
        end
        check("sat_after_20_events", int'(bus.fault_count), 15);
        wait_quiet();

        // Reset during DROP_ON with a pick pending
        do_reset();
        bus.object_drop = 1'b1;
        tick();
        bus.object_drop = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        bus.block_picked = 1'b1;
        tick();
        tick();
        check("rst_pre_green", int'(bus.led_g), 1);
        check("rst_pre_drop_count", int'(bus.drop_count), 1);
        reset = 1'b1;
        bus.block_picked = 1'b0;
        tick();
        check("rst_outputs_cleared", int'(outs()), 0);
        reset = 1'b0;
        clear_mon();
        mon_en = 1'b1;
        for (int k = 0; k < 60; k++) tick();
        mon_en = 1'b0;
        check("rst_no_blue", mon_b, 0);
        check("rst_no_busy", mon_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fault_led_driver.md
FAULT_LED_DRIVER -- requirements
Module: fault_led_driver

Interface
REQ-001 Parameter CLK_PER_MS, default 50000; clk_50M cycles per millisecond.
REQ-002 Parameter FAULT_MS, default 1000; red display time per fault event.
REQ-003 Parameter PICK_MS, default 500; blue display time per pick event.
REQ-004 Parameter BLINK_MS, default 250; green on-time and off-time per drop blink.
REQ-005 Parameter BLINKS, default 3; green blinks per drop event.
REQ-006 clk_50M  in  1  sole clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 fault_detect  in  1  level; fault present, from the fault-detection stage.
REQ-009 block_picked  in  1  level; block tower acquired.
REQ-010 object_drop  in  1  single-cycle pulse; block released at a fault.
REQ-011 led_r, led_g, led_b  out  1 each  RGB indicator, active-high.
REQ-012 fault_count  out  4  number of fault events seen, saturating.
REQ-013 drop_count  out  4  number of drop events seen, saturating.
REQ-014 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-015 Event capture:
- fault event = fault_detect 0->1 edge (registered previous value, reset value 0).
- pick event = block_picked 0->1 edge (same scheme).
- drop event = object_drop sampled high.
REQ-016 Each event class shall set its own pending flag; repeat events while a flag is already set shall merge into that flag.
REQ-017 fault_count shall increment by 1 on each fault event and saturate at 15; drop_count shall behave the same for drop events.
REQ-018 FSM states: IDLE, FAULT_SHOW, PICK_SHOW, DROP_ON, DROP_OFF.
REQ-019 In IDLE, the FSM shall select the highest-priority pending flag (drop > fault > pick), clear that flag, reset the timer, and enter DROP_ON, FAULT_SHOW or PICK_SHOW respectively.
REQ-020 A flag set in the same cycle that IDLE consumes it shall be consumed, not retained.
REQ-021 Timer:
- a ms prescaler counts 0..CLK_PER_MS-1;
- a ms counter increments at each prescaler wrap;
- a state ends in the cycle the ms counter reaches its *_MS value;
- prescaler and ms counter are both zeroed on every state entry.
REQ-022 FAULT_SHOW: led_r=1, others 0; on expiry go to IDLE.
REQ-023 PICK_SHOW: led_b=1, others 0; on expiry go to IDLE.
REQ-024 DROP_ON: led_g=1, others 0; on expiry go to DROP_OFF.
REQ-025 DROP_OFF: all LEDs 0; on expiry, increment the blink counter.
- If the counter is now BLINKS, go to IDLE and clear the counter.
- Otherwise go to DROP_ON.
REQ-026 An active display shall never be pre-empted; events arriving during a display shall only set pending flags.
REQ-027 In IDLE, all LEDs shall be 0.
REQ-028 LED outputs shall be registered, and shall change in the cycle after the state change.
REQ-029 Counter widths: the prescaler shall be sized for CLK_PER_MS and the ms counter for the largest *_MS parameter; neither shall wrap within a state.

Reset
REQ-030 While reset is high, in the next clock edge:
- state = IDLE;
- all pending flags, edge registers, timers and the blink counter = 0;
- led_r = led_g = led_b = 0, fault_count = 0, drop_count = 0, busy = 0.
REQ-031 Reset asserted mid-display shall abort the display immediately and discard all pending events.
REQ-032 Inputs seen during the reset cycle shall not generate events.

Structure
REQ-033 A shared package shall hold the FSM state encoding and the default timing constants (CLK_PER_MS, FAULT_MS, PICK_MS, BLINK_MS, BLINKS).
REQ-034 The prescaler plus ms counter shall be one sub-module, ms_timer, with inputs clear and a target value and output done.

Verification
Bench runs with CLK_PER_MS=10, FAULT_MS=4, PICK_MS=3, BLINK_MS=2, BLINKS=3.
REQ-035 Single fault: fault_detect rises and stays high -> led_r high for 40 cycles, then IDLE; fault_count=1; no retrigger while the level is held.
REQ-036 Single drop: object_drop pulse -> green pattern of 20 on / 20 off repeated 3 times (120 cycles), then busy=0; drop_count=1.
REQ-037 Simultaneous events: fault, pick and drop events in the same cycle from IDLE -> display order drop, then fault, then pick; total busy time 120+40+30 cycles.
REQ-038 Merging: 3 fault events during one drop display -> exactly one red display afterwards; fault_count=3.
REQ-039 Saturation: 20 fault events -> fault_count holds at 15.
REQ-040 Reset mid-operation: reset asserted during DROP_ON with a pick pending -> next cycle all outputs 0 and IDLE; no blue display follows.
